// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    localparam logic MEM_RD = 1'b1;
    localparam logic MEM_WR = 1'b0;

    // Read data returned to the requester when memory never acknowledges.
    localparam logic [31:0] TIMEOUT_RDATA = 32'h0;

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// Watchdog for the arbiter's WAIT states: counts cycles spent waiting for
// mem_ack and flags the last permitted cycle.
module mem_arbiter_watchdog #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam int unsigned CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] count;

    // Cycle counter: advances each cycle in WAIT, saturates, cleared after the response.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (run && (count != CW'(MAX_WAIT))) begin
            count <= count + 1'b1;
        end
    end

    // During the MAX_WAIT-th waiting cycle the count still reads MAX_WAIT-1;
    // flagging it here lets the arbiter leave WAIT on the edge where the count
    // reaches MAX_WAIT, so mem_req stays high for exactly MAX_WAIT cycles.
    assign expired = run && (count == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data
// accesses, one transaction at a time, with a watchdog on mem_ack.
// Optional feature: define MEM_ARBITER_ROUND_ROBIN_EN for round-robin
// priority on contention; otherwise data always beats instruction fetch.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_req,
    input  logic              d_rd_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_req,
    output logic              mem_rd_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              err
);

    arb_state_t        state, state_nxt;
    logic              mem_req_nxt, mem_rd_wr_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_nxt, i_rdata_nxt, d_rdata_nxt;
    logic              i_ready_nxt, d_ready_nxt, err_nxt;
    logic              grant_d;
    logic              wd_run, wd_clear, wd_expired;

    assign wd_run   = (state == WAIT_I) || (state == WAIT_D);
    assign wd_clear = (state == RESP);

    mem_arbiter_watchdog #(
        .MAX_WAIT(MAX_WAIT)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .run    (wd_run),
        .clear  (wd_clear),
        .expired(wd_expired)
    );

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    // 1 = data wins the next contention; reset value gives the first one to data.
    logic prio_data;

    assign grant_d = d_req && (!i_req || prio_data);

    // Priority flag: hand precedence to whichever side was not just granted.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_data <= 1'b1;
        end else if (state == IDLE && (d_req || i_req)) begin
            prio_data <= !grant_d;
        end
    end
`else
    // Data access belongs to the older instruction, so it always wins.
    assign grant_d = d_req;
`endif

    // Next-state and next-output logic for the transaction sequencer.
    always_comb begin
        state_nxt     = state;
        mem_req_nxt   = mem_req;
        mem_rd_wr_nxt = mem_rd_wr;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        i_rdata_nxt   = i_rdata;
        d_rdata_nxt   = d_rdata;
        i_ready_nxt   = 1'b0;
        d_ready_nxt   = 1'b0;
        err_nxt       = 1'b0;

        case (state)
            IDLE: begin
                if (grant_d) begin
                    mem_addr_nxt  = d_addr;
                    mem_rd_wr_nxt = d_rd_wr;
                    mem_wdata_nxt = d_wdata;
                    mem_req_nxt   = 1'b1;
                    state_nxt     = WAIT_D;
                end else if (i_req) begin
                    mem_addr_nxt  = i_addr;
                    mem_rd_wr_nxt = MEM_RD;
                    mem_req_nxt   = 1'b1;
                    state_nxt     = WAIT_I;
                end
            end

            WAIT_I, WAIT_D: begin
                if (mem_ack || wd_expired) begin
                    mem_req_nxt = 1'b0;
                    state_nxt   = RESP;
                    err_nxt     = !mem_ack;
                    if (state == WAIT_I) begin
                        i_ready_nxt = 1'b1;
                        i_rdata_nxt = mem_ack ? mem_rdata : DATA_W'(TIMEOUT_RDATA);
                    end else begin
                        d_ready_nxt = 1'b1;
                        if (mem_rd_wr != MEM_WR) begin
                            d_rdata_nxt = mem_ack ? mem_rdata : DATA_W'(TIMEOUT_RDATA);
                        end
                    end
                end
            end

            RESP: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_rd_wr <= MEM_RD;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            mem_req   <= mem_req_nxt;
            mem_rd_wr <= mem_rd_wr_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            i_rdata   <= i_rdata_nxt;
            d_rdata   <= d_rdata_nxt;
            i_ready   <= i_ready_nxt;
            d_ready   <= d_ready_nxt;
            err       <= err_nxt;
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the processor's instruction-fetch port and its data port.
- Sits between the mips core (instr_addr/instr_in and data_addr/data_out/data_in/data_rd_wr) and the memory model or controller.
- Sequences one memory transaction at a time through a small FSM, with fixed or round-robin priority and a watchdog on memory acknowledge.

Parameters:
- ADDR_W, 32, address width of all address ports.
- DATA_W, 32, data width of all data ports.
- MAX_WAIT, 15, cycles in WAIT without mem_ack before the watchdog aborts the transaction; legal range 1..255.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- i_req  in  1  instruction-fetch request; held until i_ready.
- i_addr  in  ADDR_W  fetch address; stable while i_req=1.
- i_rdata  out  DATA_W  fetched word; valid while i_ready=1.
- i_ready  out  1  one-cycle completion pulse for the fetch.
- d_req  in  1  data request; held until d_ready.
- d_rd_wr  in  1  1 = read, 0 = write (processor convention).
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data; valid while d_ready=1 on a read.
- d_ready  out  1  one-cycle completion pulse for the data access.
- mem_req  out  1  memory request; held until mem_ack.
- mem_rd_wr  out  1  1 = read, 0 = write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; sampled on mem_ack.
- mem_ack  in  1  memory completion; valid only while mem_req=1.
- err  out  1  one-cycle pulse with the ready of a timed-out transaction.

Behaviour:
- Clocking and reset:
  - All outputs are registered.
  - Single clock clk; synchronous active-high reset.
  - Reset values: state=IDLE; mem_req=0; mem_rd_wr=1; mem_addr=0; mem_wdata=0; i_ready=0; d_ready=0; i_rdata=0; d_rdata=0; err=0; watchdog count=0; priority flag=data.
- FSM states:
  - IDLE: no transaction in flight.
  - WAIT_I: fetch in flight, mem_req=1.
  - WAIT_D: data access in flight, mem_req=1.
  - RESP: ready pulse cycle.
- IDLE transitions:
  - d_req=1: latch d_addr, d_rd_wr and d_wdata into the mem_* registers; go to WAIT_D.
  - Else i_req=1: latch i_addr and set mem_rd_wr=1; go to WAIT_I.
  - Both requests high: data wins, since the data access belongs to the older instruction.
- WAIT_x:
  - mem_req=1 and the mem_* fields are held constant.
  - mem_ack=1: capture mem_rdata into i_rdata (fetch) or d_rdata (data read); a data write leaves d_rdata unchanged. Go to RESP and clear mem_req.
  - Watchdog counts cycles spent in WAIT_x. When it reaches MAX_WAIT with no ack: clear mem_req; load rdata with 0 on a read; set err=1; go to RESP.
  - An ack in the same cycle the count reaches MAX_WAIT wins: normal completion, err=0.
- RESP:
  - The ready of the granted requester is 1 for exactly one cycle; err is 1 only on timeout.
  - Next state is IDLE, with the counter cleared.
  - The requester must drop req, or present a new request, in the cycle after ready. New requests are only sampled in IDLE.
- Latency: req seen in IDLE at cycle 0 → mem_req at cycle 1 → mem_ack at cycle k≥1 → ready at cycle k+1. The minimum is 2 cycles from req to ready.
- Ignored inputs:
  - mem_ack outside WAIT_x.
  - Requests arriving during WAIT or RESP, until the next IDLE.
- Reset mid-transaction: the transaction is abandoned and every output returns to its reset value on the next edge. No ready or err is issued for it.

Optional Feature:
- Macro: MEM_ARBITER_ROUND_ROBIN_EN.
- Defined:
  - A one-bit last-grant flag is updated on every grant.
  - When both requests are high in IDLE, the requester not granted last wins.
  - Reset sets the flag so that the first contention goes to data.
- Undefined: fixed data-over-instruction priority; the flag logic is absent.

Decomposition:
- Package mem_arbiter_pkg:
  - State enum arb_state_t {IDLE, WAIT_I, WAIT_D, RESP}.
  - Constants MEM_RD=1'b1 and MEM_WR=1'b0.
  - Constant TIMEOUT_RDATA=32'h0.
- Sub-module mem_arbiter_watchdog:
  - Inputs: clk, reset, run, clear.
  - Output: expired.
  - Parameterised by MAX_WAIT; counter width is $clog2(MAX_WAIT+1).

Test Plan:
- Fetch with no contention: i_req=1, i_addr=0x100, mem_ack on the first cycle with mem_rdata=0x2402000A → mem_addr=0x100 and mem_rd_wr=1 at cycle 1; i_ready=1 with i_rdata=0x2402000A at cycle 2; err=0.
- Write: d_req=1, d_rd_wr=0, d_addr=0x7FC, d_wdata=0xCAFEF00D, ack after 3 cycles → mem_rd_wr=0 and mem_wdata=0xCAFEF00D held for 3 cycles; d_ready pulses once; d_rdata unchanged.
- Contention: i_req=1 and d_req=1 together, in two successive rounds → without the macro, data is granted both rounds. With MEM_ARBITER_ROUND_ROBIN_EN, data is granted first, then instruction.
- Timeout: MAX_WAIT=4, d_req read, mem_ack never asserted → mem_req high 4 cycles then 0; d_ready=1, err=1, d_rdata=0 in one cycle; FSM back in IDLE.
- Boundary and ignored inputs:
  - mem_ack asserted in the same cycle the count reaches 4 → normal completion, err=0.
  - mem_ack asserted while in IDLE → no response.
- Reset mid-transaction: reset in the cycle after mem_req rises → next cycle mem_req=0, no ready pulse; a fresh i_req after reset completes normally.
